leg_solver: RTL

LEG_SOLVER -- requirements
Module: leg_solver

---
 rtl/leg_solver_pkg.sv | 14 +
 rtl/leg_solver_if.sv | 18 +
 rtl/leg_solver_isqrt_iter.sv | 45 ++++
 rtl/leg_solver.sv | 101 ++++++++++
 4 files changed

// File: rtl/leg_solver_pkg.sv
// Shared width default and FSM state encoding for the leg solver.
// Imported by the interface, the top and the square-root core.
package leg_solver_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ROOT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/leg_solver_if.sv
// Request/result bundle for leg_solver: operands and start in, status and result out.
// The master drives the request side; the solver (slave) drives the result side.
interface leg_solver_if
    import leg_solver_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         start;
    logic [W-1:0] h_in;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic [W-1:0] leg_out;
    logic         err;

    modport master (output start, h_in, x_in, input busy, done, leg_out, err);
    modport slave  (input start, h_in, x_in, output busy, done, leg_out, err);
endinterface

// File: rtl/leg_solver_isqrt_iter.sv
// Restoring integer square root, one result bit per step, MSB first; W steps after load.
// No backpressure: load/step are strobes from the owner, finish marks the final step.
module isqrt_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [2*W-1:0] diff,
    output logic [W-1:0]   root_nxt,
    output logic           finish
);

    logic [W-1:0]   acc;
    logic [W-1:0]   bit_m;
    logic [W-1:0]   trial;
    logic [2*W-1:0] trial_ext;
    logic [2*W-1:0] trial_sq;

    // root_nxt is the accumulator value after the current step, so the owner
    // can capture the final root on the same edge as the last step.
    always_comb begin
        trial     = acc | bit_m;
        trial_ext = {{W{1'b0}}, trial};
        trial_sq  = trial_ext * trial_ext;
        root_nxt  = (trial_sq <= diff) ? trial : acc;
    end

    assign finish = bit_m[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            bit_m <= '0;
        end else if (load) begin
            acc   <= '0;
            bit_m <= {1'b1, {(W-1){1'b0}}};
        end else if (step) begin
            acc   <= root_nxt;
            bit_m <= bit_m >> 1;
        end
    end

endmodule

// File: rtl/leg_solver.sv
// Computes floor(sqrt(h^2 - x^2)) with fixed W+1 enabled-edge latency from start to done.
// No queuing: start is only sampled in IDLE; ena=0 freezes everything.
module leg_solver
    import leg_solver_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    leg_solver_if.slave   bus
);

    state_t         state;
    logic [W-1:0]   h_r;
    logic [W-1:0]   x_r;
    logic [2*W-1:0] diff_r;
    logic           err_flag;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   leg_r;
    logic           err_r;

    logic [2*W-1:0] h_ext;
    logic [2*W-1:0] x_ext;
    logic [2*W-1:0] sq_diff;
    logic           core_load;
    logic           core_step;
    logic [W-1:0]   root_nxt;
    logic           core_finish;

    always_comb begin
        h_ext   = {{W{1'b0}}, h_r};
        x_ext   = {{W{1'b0}}, x_r};
        sq_diff = (h_ext * h_ext) - (x_ext * x_ext);
    end

    assign core_load = ena && (state == SQUARE);
    assign core_step = ena && (state == ROOT);

    isqrt_iter #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .diff     (diff_r),
        .root_nxt (root_nxt),
        .finish   (core_finish)
    );

    // leg_out/err are only reloaded at the done edge so they stay stable between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            h_r      <= '0;
            x_r      <= '0;
            diff_r   <= '0;
            err_flag <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            leg_r    <= '0;
            err_r    <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        h_r    <= bus.h_in;
                        x_r    <= bus.x_in;
                        busy_r <= 1'b1;
                        state  <= SQUARE;
                    end
                end
                SQUARE: begin
                    err_flag <= (x_r > h_r);
                    diff_r   <= (x_r > h_r) ? '0 : sq_diff;
                    state    <= ROOT;
                end
                ROOT: begin
                    if (core_finish) begin
                        leg_r  <= root_nxt;
                        err_r  <= err_flag;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.leg_out = leg_r;
    assign bus.err     = err_r;

endmodule
